// File: rtl/instruction_fetch.sv
// Instruction fetch: credit-limited imem requests, in-order {pc,word} queue to decode, redirect flush
// with stale-response drop. Optional same-cycle response bypass when IFETCH_BYPASS_EN is defined.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          QUEUE_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        fetch_en,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc
);

   localparam int             AW      = $clog2(QUEUE_DEPTH);
   localparam int             CW      = AW + 1;
   localparam logic [CW-1:0]  ONE     = CW'(1);
   localparam logic [AW-1:0]  PONE    = AW'(1);
   localparam logic [CW:0]    DEPTH_C = (CW+1)'(QUEUE_DEPTH);

   typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_e;

   state_e        state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [CW-1:0] outstanding_q, outstanding_d;
   logic [CW-1:0] drop_q, drop_d;

   // PC FIFO: one entry per accepted request still owed a non-dropped response
   logic [31:0]   pcf_mem_q [QUEUE_DEPTH];
   logic [AW-1:0] pcf_wr_q, pcf_wr_d, pcf_rd_q, pcf_rd_d;
   logic [CW-1:0] pcf_cnt_q, pcf_cnt_d;
   logic [31:0]   pcf_head;

   logic [63:0]   iq_mem_q [QUEUE_DEPTH];
   logic [AW-1:0] iq_wr_q, iq_wr_d, iq_rd_q, iq_rd_d;
   logic [CW-1:0] iq_cnt_q, iq_cnt_d;
   logic [63:0]   iq_head;

   logic          req_fire;
   logic          resp_keep;
   logic          credit_ok;
   logic          bypass;
   logic          iq_nonempty;
   logic          iq_push;
   logic          iq_pop;
   logic [CW:0]   in_use;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A request already presented must not be withdrawn just because fetch_en dropped
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (fetch_en) state_d = FETCH;
         FETCH:   if (!fetch_en && !(imem_req_valid && !imem_req_ready)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      imem_req_valid = 1'b0;
      if ((state_q == FETCH) && credit_ok && !redirect_valid) imem_req_valid = 1'b1;
   end

   assign imem_req_addr = fetch_pc_q;
   assign in_use        = {1'b0, outstanding_q} + {1'b0, iq_cnt_q};
   assign credit_ok     = (in_use < DEPTH_C);
   assign req_fire      = imem_req_valid & imem_req_ready;
   assign resp_keep     = imem_resp_valid & (drop_q == '0) & !redirect_valid & (pcf_cnt_q != '0);
   assign iq_nonempty   = (iq_cnt_q != '0);
   assign pcf_head      = pcf_mem_q[pcf_rd_q];
   assign iq_head       = iq_mem_q[iq_rd_q];

`ifdef IFETCH_BYPASS_EN
   assign bypass = resp_keep & !iq_nonempty;
`else
   assign bypass = 1'b0;
`endif

   assign iq_push    = resp_keep & !(bypass & inst_ready);
   assign iq_pop     = iq_nonempty & inst_ready & !redirect_valid;
   assign inst_valid = iq_nonempty | bypass;

   always_comb begin
      inst_data = '0;
      inst_pc   = '0;
      if (iq_nonempty) begin
         inst_data = iq_head[31:0];
         inst_pc   = iq_head[63:32];
      end else if (bypass) begin
         inst_data = imem_resp_data;
         inst_pc   = pcf_head;
      end
   end

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      if (redirect_valid) fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
      else if (req_fire)  fetch_pc_d = fetch_pc_q + 32'd4;
   end

   always_comb begin
      outstanding_d = outstanding_q;
      if (req_fire && !imem_resp_valid)      outstanding_d = outstanding_q + ONE;
      else if (!req_fire && imem_resp_valid) outstanding_d = outstanding_q - ONE;
   end

   // A response landing in the redirect cycle is already discarded, so it is not counted again
   always_comb begin
      drop_d = drop_q;
      if (redirect_valid)                      drop_d = outstanding_q - (imem_resp_valid ? ONE : '0);
      else if (imem_resp_valid && drop_q != '0) drop_d = drop_q - ONE;
   end

   always_comb begin
      pcf_wr_d  = pcf_wr_q;
      pcf_rd_d  = pcf_rd_q;
      pcf_cnt_d = pcf_cnt_q;
      if (redirect_valid) begin
         pcf_wr_d  = '0;
         pcf_rd_d  = '0;
         pcf_cnt_d = '0;
      end else begin
         if (req_fire)  pcf_wr_d = pcf_wr_q + PONE;
         if (resp_keep) pcf_rd_d = pcf_rd_q + PONE;
         pcf_cnt_d = pcf_cnt_q + (req_fire ? ONE : '0) - (resp_keep ? ONE : '0);
      end
   end

   always_comb begin
      iq_wr_d  = iq_wr_q;
      iq_rd_d  = iq_rd_q;
      iq_cnt_d = iq_cnt_q;
      if (redirect_valid) begin
         iq_wr_d  = '0;
         iq_rd_d  = '0;
         iq_cnt_d = '0;
      end else begin
         if (iq_push) iq_wr_d = iq_wr_q + PONE;
         if (iq_pop)  iq_rd_d = iq_rd_q + PONE;
         iq_cnt_d = iq_cnt_q + (iq_push ? ONE : '0) - (iq_pop ? ONE : '0);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         fetch_pc_q    <= RESET_PC & 32'hFFFF_FFFC;
         outstanding_q <= '0;
         drop_q        <= '0;
         pcf_wr_q      <= '0;
         pcf_rd_q      <= '0;
         pcf_cnt_q     <= '0;
         iq_wr_q       <= '0;
         iq_rd_q       <= '0;
         iq_cnt_q      <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
         pcf_wr_q      <= pcf_wr_d;
         pcf_rd_q      <= pcf_rd_d;
         pcf_cnt_q     <= pcf_cnt_d;
         iq_wr_q       <= iq_wr_d;
         iq_rd_q       <= iq_rd_d;
         iq_cnt_q      <= iq_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (req_fire) pcf_mem_q[pcf_wr_q] <= fetch_pc_q;
      if (iq_push)  iq_mem_q[iq_wr_q]   <= {pcf_head, imem_resp_data};
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: randomized memory/decode behaviour against an in-order PC-stream model.
module tb_instruction_fetch;

   localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
   localparam int          DEPTH  = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        fetch_en;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;

   instruction_fetch #(.RESET_PC(RST_PC), .QUEUE_DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n), .fetch_en(fetch_en),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   mreq_t       memq[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          n_acc = 0;
   int          n_deliv = 0;
   int unsigned ready_pct, iready_pct, lat_min, lat_max;
   logic [31:0] exp_pc, exp_req, prev_addr, cap_pc, cap_req;
   logic        prev_stall = 1'b0;
   logic        after_redir = 1'b0;
   logic        cap_pc_arm = 1'b0;
   logic        cap_req_arm = 1'b0;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive memory/decode/redirect, then check against the stream model.
   task automatic cycle(input logic redir, input logic [31:0] tgt);
      logic resp;
      @(negedge clk);
      resp = (memq.size() > 0) && (memq[0].due <= cyc);
      imem_resp_valid = resp;
      if (resp) imem_resp_data = word_of(memq[0].addr);
      else      imem_resp_data = $urandom();
      imem_req_ready = ($urandom_range(99) < ready_pct);
      inst_ready     = ($urandom_range(99) < iready_pct);
      redirect_valid = redir;
      redirect_pc    = tgt;
      #1;
      if (prev_stall && !redir) begin
         check("req_hold_vld", 32'(imem_req_valid), 32'd1);
         check("req_hold_addr", imem_req_addr, prev_addr);
      end
      if (redir)       check("redir_no_req", 32'(imem_req_valid), 32'd0);
      if (after_redir) check("inst_vld_after_redir", 32'(inst_valid), 32'd0);
      if (inst_valid && inst_ready) begin
         check("inst_pc", inst_pc, exp_pc);
         check("inst_data", inst_data, word_of(exp_pc));
         if (cap_pc_arm) begin
            cap_pc     = inst_pc;
            cap_pc_arm = 1'b0;
         end
         exp_pc = exp_pc + 32'd4;
         n_deliv++;
      end
      if (imem_req_valid && imem_req_ready) begin
         check("req_addr", imem_req_addr, exp_req);
         if (cap_req_arm) begin
            cap_req     = imem_req_addr;
            cap_req_arm = 1'b0;
         end
         memq.push_back('{imem_req_addr, cyc + int'($urandom_range(lat_max, lat_min))});
         exp_req = exp_req + 32'd4;
         n_acc++;
      end
      if (resp) void'(memq.pop_front());
      check("credit_limit", 32'(memq.size() <= DEPTH), 32'd1);
      if (redir) begin
         exp_pc  = tgt & 32'hFFFF_FFFC;
         exp_req = tgt & 32'hFFFF_FFFC;
      end
      after_redir = redir;
      prev_stall  = imem_req_valid && !imem_req_ready && !redir;
      prev_addr   = imem_req_addr;
      cyc++;
   endtask

   // Reset held across ncyc rising edges; returns #1 into the first cycle out of reset.
   task automatic reset_dut(input int ncyc);
      @(negedge clk);
      reset_n         = 1'b0;
      redirect_valid  = 1'b0;
      imem_resp_valid = 1'b0;
      memq.delete();
      repeat (ncyc) @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("rst_req_vld", 32'(imem_req_valid), 32'd0);
      check("rst_req_addr", imem_req_addr, RST_PC);
      check("rst_inst_vld", 32'(inst_valid), 32'd0);
      check("rst_inst_data", inst_data, 32'd0);
      check("rst_inst_pc", inst_pc, 32'd0);
      exp_pc      = RST_PC;
      exp_req     = RST_PC;
      prev_stall  = 1'b0;
      after_redir = 1'b0;
      cyc         = cyc + ncyc + 1;
   endtask

   initial begin
      logic        redirected;
      logic [31:0] held;
      reset_n = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0; inst_ready = 1'b0;
      ready_pct = 100; iready_pct = 0; lat_min = 1; lat_max = 1;
      cap_pc = '0; cap_req = '0;

      // Decode stalled: exactly DEPTH requests, starting at RESET_PC and wrapping through 0
      reset_dut(2);
      fetch_en = 1'b1;
      n_acc = 0;
      cycle(1'b0, '0);
      check("first_req_vld", 32'(imem_req_valid), 32'd1);
      check("first_req_addr", imem_req_addr, RST_PC);
      repeat (11) cycle(1'b0, '0);
      check("stall_acc_count", 32'(n_acc), 32'(DEPTH));
      check("stall_req_vld", 32'(imem_req_valid), 32'd0);
      check("stall_inst_vld", 32'(inst_valid), 32'd1);

      // Release decode; then one instruction per cycle in steady state
      iready_pct = 100;
      repeat (10) cycle(1'b0, '0);
      n_deliv = 0;
      repeat (20) cycle(1'b0, '0);
      check("throughput", 32'(n_deliv), 32'd20);

      // Redirect while three responses are in flight
      lat_min = 4; lat_max = 4;
      redirected = 1'b0;
      for (int i = 0; i < 40 && !redirected; i++) begin
         if (memq.size() == 3) begin
            cycle(1'b1, 32'h0000_0103);
            redirected = 1'b1;
            cap_pc_arm = 1'b1;
         end else begin
            cycle(1'b0, '0);
         end
      end
      check("redir_reached_3", 32'(redirected), 32'd1);
      repeat (15) cycle(1'b0, '0);
      check("redir_armed_done", 32'(cap_pc_arm), 32'd0);
      check("redir_first_pc", cap_pc, 32'h0000_0100);

      // Memory not ready for 5 cycles, then a redirect during a second stall
      lat_min = 1; lat_max = 1;
      repeat (10) cycle(1'b0, '0);
      ready_pct = 0;
      cycle(1'b0, '0);
      held = imem_req_addr;
      check("hold_vld0", 32'(imem_req_valid), 32'd1);
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, '0);
         check("hold_vld", 32'(imem_req_valid), 32'd1);
         check("hold_addr", imem_req_addr, held);
      end
      cycle(1'b0, '0);
      cycle(1'b1, 32'h0000_2000);
      cycle(1'b0, '0);
      check("redir_stall_vld", 32'(imem_req_valid), 32'd1);
      check("redir_stall_addr", imem_req_addr, 32'h0000_2000);
      ready_pct = 100;
      cap_req_arm = 1'b1;
      repeat (5) cycle(1'b0, '0);
      check("redir_stall_accept", cap_req, 32'h0000_2000);

      // Randomized traffic with redirects and fetch_en toggling
      ready_pct = 70; iready_pct = 70; lat_min = 1; lat_max = 3;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(99) < 5) fetch_en = ~fetch_en;
         cycle($urandom_range(99) < 3, $urandom());
      end
      fetch_en = 1'b1;

      // One-cycle reset mid-stream, then fetch restarts at RESET_PC
      ready_pct = 100; iready_pct = 100; lat_min = 1; lat_max = 1;
      repeat (10) cycle(1'b0, '0);
      reset_dut(1);
      cap_req = '0;
      cap_req_arm = 1'b1;
      repeat (20) cycle(1'b0, '0);
      check("restart_addr", cap_req, RST_PC);

      fetch_en = 1'b0;
      repeat (10) cycle(1'b0, '0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage, placed between the program-counter logic and decode. It keeps its own fetch PC and issues word-aligned requests to instruction memory over a valid/ready channel. Returned words go into a small in-order queue and are handed to decode with their PC. A redirect (branch/jump/trap) flushes the queue and discards responses that are still in flight.

## Interface
- `RESET_PC`, 32'h0000_0000, fetch address loaded on reset
- `QUEUE_DEPTH`, 4, instruction queue entries and maximum outstanding requests (power of two, 2..8)
- `clk` in 1: single clock, rising edge
- `reset_n` in 1: synchronous, active-low reset, sampled on `clk` rising edge
- `fetch_en` in 1: permits new requests while high
- `redirect_valid` in 1: one-cycle pulse that redirects fetch
- `redirect_pc` in 32: new fetch address; bits [1:0] ignored, treated as 0
- `imem_req_valid` out 1: request valid
- `imem_req_ready` in 1: memory accepts request
- `imem_req_addr` out 32: request byte address, bits [1:0] always 0
- `imem_resp_valid` in 1: response word valid, one per accepted request, in order, at least 1 cycle after acceptance
- `imem_resp_data` in 32: response instruction word
- `inst_valid` out 1: instruction available to decode
- `inst_ready` in 1: decode consumes instruction
- `inst_data` out 32: instruction word
- `inst_pc` out 32: address of `inst_data`

## Operation
- FSM states: IDLE and FETCH. Reset enters IDLE.
  - IDLE → FETCH when `fetch_en`=1.
  - FETCH → IDLE when `fetch_en`=0 and no request is pending on the bus.
  - Outstanding responses are still collected while in IDLE.
- `fetch_pc` register: reset value `RESET_PC`. It advances by 4 on each accepted request (`imem_req_valid & imem_req_ready`) and wraps modulo 2^32 (32'hFFFF_FFFC → 0).
- Credit rule: `imem_req_valid` = FETCH & (`outstanding` + `q_count` < `QUEUE_DEPTH`) & !`redirect_valid`. A queue overflow is therefore impossible.
- Once `imem_req_valid` is asserted, it and `imem_req_addr` stay stable until accepted. Only a redirect may withdraw them.
- `outstanding` counter: +1 on accept, −1 on response, both in the same cycle leave it unchanged. Width is clog2(`QUEUE_DEPTH`)+1.
- Redirect: on the cycle `redirect_valid`=1:
  - the queue is cleared;
  - `fetch_pc` ← {`redirect_pc`[31:2],2'b00};
  - `drop_count` ← `outstanding` minus any response arriving that same cycle;
  - no request is issued that cycle.
- Responses that arrive while `drop_count`>0 are discarded and decrement `drop_count`. New requests may issue while discards are pending, because ordering guarantees correct attribution.
- Each queue entry holds {pc, word}. The pc is captured from a PC FIFO written at request acceptance, with depth equal to the queue depth and flushed on redirect.
- Simultaneous push and pop on the queue is allowed at any occupancy.
- Redirect together with `inst_ready`: the flush takes priority and the head is not counted as consumed twice. Decode sees the handshake that cycle as having completed.

## Timing
- Reset values:
  - `imem_req_valid`=0, `imem_req_addr`=`RESET_PC`
  - `inst_valid`=0, `inst_data`=0, `inst_pc`=0
  - `outstanding`=0, `drop_count`=0, queue empty, state IDLE
- Reset mid-operation: everything returns to reset values on the next edge. Responses to requests issued before reset are the memory's responsibility and must not arrive after reset.
- First request: `fetch_en`=1 in cycle R (first cycle out of reset) → FETCH at R+1 → `imem_req_valid`=1 with addr `RESET_PC` in R+1.
- Without bypass: a response in cycle N gives `inst_valid`=1 in N+1.
- Redirect in cycle N:
  - `inst_valid`=0 in N+1;
  - first request to the new target in N+1;
  - its instruction appears no earlier than N+3.
- Steady state with 1-cycle memory and `inst_ready`=1: one instruction per cycle.

## Configuration
- `IFETCH_BYPASS_EN`: adds a same-cycle bypass path.
  - Defined: when the queue is empty, a non-dropped `imem_resp_valid` drives `inst_valid`/`inst_data`/`inst_pc` combinationally in the same cycle. If `inst_ready`=1 the word is not written to the queue; otherwise it is enqueued.
  - Not defined: all outputs are driven from the queue head, with one cycle of response-to-output latency.

## Test plan
- Reset, then `fetch_en`=1, memory with 1-cycle latency, `inst_ready`=1 → addresses 0,4,8,…; `inst_pc` sequence 0,4,8 with matching data, one per cycle after the pipeline fills.
- `inst_ready`=0 with `QUEUE_DEPTH`=4 → exactly 4 requests accepted, then `imem_req_valid`=0. Releasing `inst_ready` delivers 0,4,8,12 in order.
- Redirect to 32'h0000_0103 with 3 responses outstanding → the 3 stale words are dropped. The next `inst_pc`=32'h0000_0100 and the queue was empty in between.
- `RESET_PC`=32'hFFFF_FFF8 → requests FFFF_FFF8, FFFF_FFFC, 0000_0000.
- `imem_req_ready` held low for 5 cycles → request valid and address stable throughout. A redirect during the stall withdraws the request and the next address equals the redirect target.
- Drop `reset_n` low for one cycle mid-stream → all outputs at reset values the following cycle, then fetch restarts at `RESET_PC`.
